link_frame_sync: RTL and testbench
==================================

Name: link_frame_sync

Overview:
- Sits directly downstream of the 4x-oversampling Manchester CDR in the clk_link domain.
- Consumes the recovered bit stream (bit + valid + CDR lock) and hunts for a frame sync word.
- Once synchronised, assembles each frame's payload into a parallel word, checks even parity, and flywheels across occasional sync misses.
- Presents frames to the link-layer consumer.

Parameters:
- SYNC_W, 8, sync word width in bits.
- SYNC_WORD, 8'hA7, sync pattern, transmitted MSB first.
- DATA_W, 16, payload width in bits, MSB first.
- CONFIRM_N, 2, consecutive good syncs required to assert sync_locked (1..15).
- MISS_N, 3, consecutive bad syncs that drop lock and return to HUNT (1..15).

Ports:
- clk_link  input  1  link clock, 200 MHz.
- rst_n  input  1  asynchronous active-low reset.
- bit_in  input  1  recovered data bit from CDR.
- bit_in_valid  input  1  one-cycle strobe; bit_in is valid when high.
- cdr_locked  input  1  CDR lock indicator.
- frame_data  output  DATA_W  assembled payload; held until the next frame.
- frame_valid  output  1  one-cycle pulse per delivered frame.
- frame_err  output  1  parity error flag; meaningful only with frame_valid.
- sync_locked  output  1  frame alignment acquired.

Behaviour:
- Interface: one clock, clk_link. rst_n is asynchronous assert, active-low. All state is registered.
- Reset values: frame_data=0, frame_valid=0, frame_err=0, sync_locked=0. FSM in HUNT; all counters 0.
- Bit acceptance: only cycles with bit_in_valid=1 advance any shift register or counter. The FSM holds otherwise.
- Frame format: SYNC_W sync bits, then DATA_W payload bits, then 1 even-parity bit. Parity is the XOR of the payload bits. Frame length = SYNC_W+DATA_W+1.
- FSM states:
  - HUNT: shift bit_in into a SYNC_W-bit window, LSB in, so the first bit ends up at the MSB. On window==SYNC_WORD (checked including the bit just shifted): set confirm_cnt=1, miss_cnt=0, go to PAYLOAD. If CONFIRM_N==1, also set sync_locked=1.
  - PAYLOAD: shift DATA_W bits into the payload register. After the DATA_W-th bit, go to PARITY.
  - PARITY: on the accepted bit, compute err = (XOR of payload) ^ bit. If sync_locked==1, on the next cycle load frame_data with the payload, pulse frame_valid=1 for one cycle, and set frame_err=err. Then go to SYNC_CHK with the bit counter cleared.
  - SYNC_CHK: collect SYNC_W bits, then compare against SYNC_WORD.
    - Match: miss_cnt=0; confirm_cnt increments, saturating at CONFIRM_N. When confirm_cnt reaches CONFIRM_N, set sync_locked=1. Go to PAYLOAD.
    - Mismatch: confirm_cnt=0; miss_cnt increments. If miss_cnt reaches MISS_N, set sync_locked=0, clear counters and go to HUNT. Otherwise go to PAYLOAD (flywheel); sync_locked is unchanged.
- Latency:
  - frame_valid rises exactly 1 clk_link cycle after the cycle in which the parity bit was accepted.
  - sync_locked updates in the cycle after the final sync bit is accepted.
- Frame delivery: frames whose preceding sync was a flywheeled mismatch are still delivered while sync_locked=1.
- cdr_locked=0 (level, any state): synchronous abort on the next edge.
  - Go to HUNT; clear the window, counters and sync_locked.
  - Suppress any pending frame_valid. frame_data holds its last value.
- bit_in_valid and an abort in the same cycle: the abort wins; the bit is discarded.
- Back-to-back bit_in_valid every cycle is supported with no stalls. There is no backpressure; the consumer must accept each frame_valid pulse.

Optional Feature:
- Macro: LINK_FRAME_STATS_EN.
- Defined: adds two output ports.
  - good_frames[15:0]: counts frame_valid pulses with frame_err=0.
  - parity_errs[15:0]: counts frame_valid pulses with frame_err=1.
  - Both saturate at 16'hFFFF and are cleared by rst_n only; cdr_locked loss does not clear them.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then cdr_locked=1, then 4 frames of SYNC 8'hA7, payload 16'h1234, parity 1 -> frame 1 suppressed; sync_locked=1 after sync 2; frames 2-4 each pulse frame_valid with frame_data=16'h1234 and frame_err=0; check the 1-cycle latency after the parity bit.
- Locked stream with the 3rd frame's parity bit flipped -> that frame has frame_err=1 and frame_data intact; neighbouring frames have frame_err=0; sync_locked stays 1.
- Locked stream, 2 consecutive syncs corrupted to 8'h00, then good syncs -> sync_locked stays 1; flywheeled frames are delivered; miss_cnt recovers to 0.
- Locked stream, 3 consecutive syncs corrupted -> sync_locked falls after the 3rd bad sync; no frame_valid until re-acquired and 2 good syncs are seen.
- Random bits, then sync, with bit_in_valid gaps of 0-3 idle cycles between bits -> identical frame_data sequence to the gapless run.
- cdr_locked deasserted mid-payload -> next cycle state HUNT, sync_locked=0, no frame_valid; reacquires after cdr_locked returns. With LINK_FRAME_STATS_EN defined, the counters match the counts from all scenarios above.

Source files
------------

// File: rtl/link_frame_sync.sv
// link_frame_sync
//   Frame synchroniser sitting behind the Manchester CDR in the clk_link
//   domain. Hunts for SYNC_WORD in the recovered bit stream, then tracks
//   fixed-length frames (SYNC_W sync bits, DATA_W payload bits MSB first,
//   one even-parity bit), confirms alignment over CONFIRM_N good syncs,
//   flywheels across up to MISS_N-1 bad syncs and delivers each payload.
//
// Ports:
//   clk_link      in   link clock
//   rst_n         in   asynchronous active-low reset
//   bit_in        in   recovered data bit
//   bit_in_valid  in   qualifies bit_in for one cycle
//   cdr_locked    in   CDR lock; low aborts alignment on the next edge
//   frame_data    out  last delivered payload, held between frames
//   frame_valid   out  one-cycle pulse per delivered frame
//   frame_err     out  parity error of the delivered frame
//   sync_locked   out  frame alignment acquired
//   good_frames   out  (LINK_FRAME_STATS_EN) saturating count of clean frames
//   parity_errs   out  (LINK_FRAME_STATS_EN) saturating count of parity errors
//
// Optional feature macro: LINK_FRAME_STATS_EN (adds the two counter ports).

module link_frame_sync #(
    parameter int unsigned       SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA7,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       CONFIRM_N = 2,
    parameter int unsigned       MISS_N    = 3
) (
    input  logic              clk_link,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_in_valid,
    input  logic              cdr_locked,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_valid,
    output logic              frame_err,
`ifdef LINK_FRAME_STATS_EN
    output logic [15:0]       good_frames,
    output logic [15:0]       parity_errs,
`endif
    output logic              sync_locked
);

    localparam int unsigned CNT_MAX = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [3:0]       CONFIRM_L = 4'(CONFIRM_N);
    localparam logic [3:0]       MISS_L    = 4'(MISS_N);

    localparam logic [1:0] ST_HUNT     = 2'd0;
    localparam logic [1:0] ST_PAYLOAD  = 2'd1;
    localparam logic [1:0] ST_PARITY   = 2'd2;
    localparam logic [1:0] ST_SYNC_CHK = 2'd3;

    logic [1:0]        r_state;
    logic [SYNC_W-1:0] r_win;      // hunt window, reused to collect sync bits in SYNC_CHK
    logic [DATA_W-1:0] r_pay;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [3:0]        r_conf;
    logic [3:0]        r_miss;
    logic              r_locked;
    logic [DATA_W-1:0] r_fdata;
    logic              r_fv;
    logic              r_ferr;

    logic [SYNC_W-1:0] w_win_next;
    logic [DATA_W-1:0] w_pay_next;
    logic              w_sync_hit;
    logic              w_par_err;
    logic              w_deliver;

    assign w_win_next = {r_win[SYNC_W-2:0], bit_in};
    assign w_pay_next = {r_pay[DATA_W-2:0], bit_in};
    assign w_sync_hit = (w_win_next == SYNC_WORD);
    assign w_par_err  = (^r_pay) ^ bit_in;
    // A frame leaves only if its parity bit is really accepted (an abort in
    // the same cycle discards the bit) and alignment is currently confirmed.
    assign w_deliver  = cdr_locked && bit_in_valid && (r_state == ST_PARITY) && r_locked;

    always_ff @(posedge clk_link or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_HUNT;
            r_win    <= '0;
            r_pay    <= '0;
            r_bitcnt <= '0;
            r_conf   <= '0;
            r_miss   <= '0;
            r_locked <= 1'b0;
            r_fdata  <= '0;
            r_fv     <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_fv <= 1'b0;
            if (!cdr_locked) begin
                r_state  <= ST_HUNT;
                r_win    <= '0;
                r_bitcnt <= '0;
                r_conf   <= '0;
                r_miss   <= '0;
                r_locked <= 1'b0;
            end else if (bit_in_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        r_win <= w_win_next;
                        if (w_sync_hit) begin
                            r_conf   <= 4'd1;
                            r_miss   <= '0;
                            r_bitcnt <= '0;
                            r_state  <= ST_PAYLOAD;
                            if (CONFIRM_L == 4'd1) r_locked <= 1'b1;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_pay <= w_pay_next;
                        if (r_bitcnt == DATA_LAST) begin
                            r_bitcnt <= '0;
                            r_state  <= ST_PARITY;
                        end else begin
                            r_bitcnt <= r_bitcnt + CNT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (w_deliver) begin
                            r_fv    <= 1'b1;
                            r_fdata <= r_pay;
                            r_ferr  <= w_par_err;
                        end
                        r_bitcnt <= '0;
                        r_state  <= ST_SYNC_CHK;
                    end
                    default: begin // ST_SYNC_CHK
                        r_win <= w_win_next;
                        if (r_bitcnt == SYNC_LAST) begin
                            r_bitcnt <= '0;
                            r_state  <= ST_PAYLOAD;
                            if (w_sync_hit) begin
                                r_miss <= '0;
                                // compare against N-1 so a saturated count never wraps
                                if (r_conf >= CONFIRM_L - 4'd1) begin
                                    r_conf   <= CONFIRM_L;
                                    r_locked <= 1'b1;
                                end else begin
                                    r_conf <= r_conf + 4'd1;
                                end
                            end else begin
                                r_conf <= '0;
                                if (r_miss + 4'd1 == MISS_L) begin
                                    r_miss   <= '0;
                                    r_locked <= 1'b0;
                                    r_win    <= '0;
                                    r_state  <= ST_HUNT;
                                end else begin
                                    r_miss <= r_miss + 4'd1;
                                end
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign frame_data  = r_fdata;
    assign frame_valid = r_fv;
    assign frame_err   = r_ferr;
    assign sync_locked = r_locked;

`ifdef LINK_FRAME_STATS_EN
    // Cleared by rst_n only; loss of CDR lock leaves the totals intact.
    logic [15:0] r_good;
    logic [15:0] r_perr;

    always_ff @(posedge clk_link or negedge rst_n) begin
        if (!rst_n) begin
            r_good <= '0;
            r_perr <= '0;
        end else if (w_deliver) begin
            if (w_par_err) begin
                if (r_perr != '1) r_perr <= r_perr + 16'd1;
            end else begin
                if (r_good != '1) r_good <= r_good + 16'd1;
            end
        end
    end

    assign good_frames = r_good;
    assign parity_errs = r_perr;
`endif

endmodule

// File: tb/tb_link_frame_sync.sv
// tb_link_frame_sync
//   Self-checking bench for link_frame_sync: a table of hand-derived frames,
//   hand-written abort sequences, and random bit streams checked against a
//   frame-level reference model. Optional counters are checked when
//   LINK_FRAME_STATS_EN is defined.
`timescale 1ns/100ps

module tb_link_frame_sync;

    localparam int          SYNC_W    = 8;
    localparam int          DATA_W    = 16;
    localparam int          CONFIRM_N = 2;
    localparam int          MISS_N    = 3;
    localparam logic [7:0]  SYNC_WORD = 8'hA7;

    logic        clk_link = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_in_valid = 1'b0;
    logic        cdr_locked = 1'b0;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic        sync_locked;
`ifdef LINK_FRAME_STATS_EN
    logic [15:0] good_frames;
    logic [15:0] parity_errs;
`endif

    link_frame_sync #(
        .SYNC_W   (SYNC_W),
        .SYNC_WORD(SYNC_WORD),
        .DATA_W   (DATA_W),
        .CONFIRM_N(CONFIRM_N),
        .MISS_N   (MISS_N)
    ) dut (
        .clk_link    (clk_link),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_in_valid(bit_in_valid),
        .cdr_locked  (cdr_locked),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
`ifdef LINK_FRAME_STATS_EN
        .good_frames (good_frames),
        .parity_errs (parity_errs),
`endif
        .sync_locked (sync_locked)
    );

    always #2.5 clk_link = ~clk_link;

    int errors = 0;
    int checks = 0;
    int exp_good = 0;
    int exp_perr = 0;

    typedef struct {
        logic [7:0]  sync;
        logic [15:0] payload;
        logic        flip;
        logic        exp_lock;
        logic        exp_fv;
        logic        exp_err;
    } row_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          pidx;
    } ev_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic step(input logic v, input logic b, input logic c);
        bit_in_valid = v;
        bit_in       = b;
        cdr_locked   = c;
        @(posedge clk_link);
        @(negedge clk_link);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, inout int fvc);
        for (int k = n - 1; k >= 0; k--) begin
            step(1'b1, v[k], 1'b1);
            if (frame_valid) fvc++;
        end
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [15:0] p, input logic flip,
                              output logic lk_pre, output logic lk_post, output logic fv,
                              output logic [15:0] d, output logic e, output int stray);
        stray = 0;
        send_bits({24'd0, s} >> 1, 7, stray);
        lk_pre = sync_locked;
        send_bits({31'd0, s[0]}, 1, stray);
        lk_post = sync_locked;
        send_bits({16'd0, p}, 16, stray);
        step(1'b1, (^p) ^ flip, 1'b1);
        fv = frame_valid;
        d  = frame_data;
        e  = frame_err;
    endtask

    // Frame-level reference: slide bitwise while hunting, then jump a whole
    // frame at a time. lk[i] is the expected sync_locked after bit i.
    function automatic void model(input bit b[$], output ev_t evq[$], output bit lk[$]);
        int n, i, conf, miss;
        bit locked, lost;
        logic [7:0]  w, s;
        logic [15:0] d;
        logic        e;
        n = b.size(); i = 0; conf = 0; miss = 0; locked = 0; w = '0;
        evq.delete();
        lk.delete();
        while (i < n) begin
            w = {w[6:0], b[i]};
            i++;
            if (w != SYNC_WORD) begin
                lk.push_back(locked);
                continue;
            end
            conf = 1;
            miss = 0;
            if (CONFIRM_N == 1) locked = 1;
            lk.push_back(locked);
            lost = 0;
            while (!lost && i < n) begin
                if (i + DATA_W + 1 > n) begin
                    while (i < n) begin lk.push_back(locked); i++; end
                end else begin
                    d = '0;
                    for (int k = 0; k < DATA_W; k++) d = {d[14:0], b[i+k]};
                    e = (^d) ^ b[i+DATA_W];
                    if (locked) evq.push_back('{d, e, i + DATA_W});
                    for (int k = 0; k <= DATA_W; k++) lk.push_back(locked);
                    i += DATA_W + 1;
                    if (i + SYNC_W > n) begin
                        while (i < n) begin lk.push_back(locked); i++; end
                    end else begin
                        s = '0;
                        for (int k = 0; k < SYNC_W; k++) s = {s[6:0], b[i+k]};
                        for (int k = 0; k < SYNC_W - 1; k++) lk.push_back(locked);
                        if (s == SYNC_WORD) begin
                            miss = 0;
                            conf = (conf + 1 > CONFIRM_N) ? CONFIRM_N : conf + 1;
                            if (conf == CONFIRM_N) locked = 1;
                        end else begin
                            conf = 0;
                            miss++;
                            if (miss == MISS_N) begin
                                locked = 0; miss = 0; lost = 1; w = '0;
                            end
                        end
                        lk.push_back(locked);
                        i += SYNC_W;
                    end
                end
            end
        end
    endfunction

    function automatic void gen_stream(output bit q[$], input int nframes);
        logic [7:0]  s;
        logic [15:0] p;
        int lead;
        q.delete();
        lead = $urandom_range(20, 0);
        for (int k = 0; k < lead; k++) q.push_back(1'($urandom));
        for (int f = 0; f < nframes; f++) begin
            s = ($urandom_range(9, 0) < 2) ? 8'($urandom) : SYNC_WORD;
            p = 16'($urandom);
            for (int k = 7; k >= 0; k--) q.push_back(s[k]);
            for (int k = 15; k >= 0; k--) q.push_back(p[k]);
            q.push_back((^p) ^ ($urandom_range(7, 0) == 0));
        end
    endfunction

    task automatic run_seg(input bit bits[$], input int max_gap, input string tag);
        ev_t exp_q[$];
        ev_t got_q[$];
        bit  exp_lock[$];
        int  g;
        model(bits, exp_q, exp_lock);
        for (int i = 0; i < bits.size(); i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                step(1'b0, 1'($urandom), 1'b1);
                if (frame_valid) got_q.push_back('{frame_data, frame_err, -1});
            end
            step(1'b1, bits[i], 1'b1);
            if (frame_valid) got_q.push_back('{frame_data, frame_err, i});
            chk($sformatf("%s lock bit%0d", tag, i), sync_locked, exp_lock[i]);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b1);
            if (frame_valid) got_q.push_back('{frame_data, frame_err, -1});
        end
        chk($sformatf("%s frame count", tag), got_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
            chk($sformatf("%s frame%0d data", tag, j), got_q[j].data, exp_q[j].data);
            chk($sformatf("%s frame%0d err", tag, j), got_q[j].err, exp_q[j].err);
            chk($sformatf("%s frame%0d parity-bit index", tag, j), got_q[j].pidx, exp_q[j].pidx);
        end
        foreach (exp_q[j]) begin
            if (exp_q[j].err) exp_perr++;
            else exp_good++;
        end
    endtask

    row_t        rows[17];
    logic        lp, lq, fv, e, prev_lock;
    logic [15:0] d;
    int          stray;
    bit          stream[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // sync, payload, flip parity, lock after sync, frame_valid, frame_err
        rows[0]  = '{8'hA7, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0}; // acquire: suppressed
        rows[1]  = '{8'hA7, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0}; // 2nd sync locks
        rows[2]  = '{8'hA7, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0};
        rows[3]  = '{8'hA7, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0};
        rows[4]  = '{8'hA7, 16'h5A5A, 1'b0, 1'b1, 1'b1, 1'b0};
        rows[5]  = '{8'hA7, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b1}; // parity flipped
        rows[6]  = '{8'hA7, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0};
        rows[7]  = '{8'h00, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b0}; // miss 1 (flywheel)
        rows[8]  = '{8'h00, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b0}; // miss 2 (flywheel)
        rows[9]  = '{8'hA7, 16'h3333, 1'b0, 1'b1, 1'b1, 1'b0}; // miss count recovers
        rows[10] = '{8'hA7, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b0};
        rows[11] = '{8'h00, 16'hAAAA, 1'b0, 1'b1, 1'b1, 1'b0};
        rows[12] = '{8'h00, 16'hBBBB, 1'b0, 1'b1, 1'b1, 1'b0};
        rows[13] = '{8'h00, 16'hCCCC, 1'b0, 1'b0, 1'b0, 1'b0}; // 3rd miss: lock lost
        rows[14] = '{8'hA7, 16'hDDDD, 1'b0, 1'b0, 1'b0, 1'b0}; // re-hunt, confirm 1
        rows[15] = '{8'hA7, 16'hEEEE, 1'b0, 1'b1, 1'b1, 1'b0}; // confirm 2: locked
        rows[16] = '{8'hA7, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};

        // reset values
        repeat (3) @(negedge clk_link);
        chk("reset frame_data", frame_data, 16'h0000);
        chk("reset frame_valid", frame_valid, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset sync_locked", sync_locked, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1);

        // directed frame table
        prev_lock = 1'b0;
        for (int r = 0; r < 17; r++) begin
            send_frame(rows[r].sync, rows[r].payload, rows[r].flip, lp, lq, fv, d, e, stray);
            chk($sformatf("row%0d lock before last sync bit", r), lp, prev_lock);
            chk($sformatf("row%0d lock after sync", r), lq, rows[r].exp_lock);
            chk($sformatf("row%0d frame_valid after parity", r), fv, rows[r].exp_fv);
            if (rows[r].exp_fv) begin
                chk($sformatf("row%0d frame_data", r), d, rows[r].payload);
                chk($sformatf("row%0d frame_err", r), e, rows[r].exp_err);
                if (rows[r].exp_err) exp_perr++;
                else exp_good++;
            end
            chk($sformatf("row%0d stray frame_valid", r), stray, 0);
            prev_lock = rows[r].exp_lock;
        end
        step(1'b0, 1'b0, 1'b1);
        chk("frame_valid pulse width", frame_valid, 1'b0);

        // abort mid-payload while locked
        stray = 0;
        send_bits(32'hA7, 8, stray);
        send_bits(32'h15, 5, stray);
        step(1'b1, 1'b1, 1'b0);
        chk("abort sync_locked", sync_locked, 1'b0);
        chk("abort frame_valid", frame_valid, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("after abort sync_locked", sync_locked, 1'b0);
        chk("after abort frame_valid", frame_valid, 1'b0);
        chk("abort seq stray frame_valid", stray, 0);

        // reacquire from HUNT after the abort, with gaps
        gen_stream(stream, 8);
        run_seg(stream, 2, "reacq");

        // same random stream gapless and with 0-3 idle cycles between bits
        gen_stream(stream, 12);
        step(1'b0, 1'b0, 1'b0);
        run_seg(stream, 0, "gapless");
        step(1'b0, 1'b0, 1'b0);
        run_seg(stream, 3, "gapped");

        // abort coinciding with an accepted parity bit
        step(1'b0, 1'b0, 1'b0);
        send_frame(8'hA7, 16'h1111, 1'b0, lp, lq, fv, d, e, stray);
        chk("pabort frame1 frame_valid", fv, 1'b0);
        send_frame(8'hA7, 16'h2222, 1'b0, lp, lq, fv, d, e, stray);
        chk("pabort frame2 frame_valid", fv, 1'b1);
        chk("pabort frame2 frame_data", d, 16'h2222);
        exp_good++;
        stray = 0;
        send_bits(32'hA7, 8, stray);
        send_bits(32'h3333, 16, stray);
        step(1'b1, ^16'h3333, 1'b0);
        chk("pabort frame_valid suppressed", frame_valid, 1'b0);
        chk("pabort sync_locked", sync_locked, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("pabort frame_valid next cycle", frame_valid, 1'b0);
        chk("pabort frame_data held", frame_data, 16'h2222);

`ifdef LINK_FRAME_STATS_EN
        chk("stats good_frames", good_frames, exp_good);
        chk("stats parity_errs", parity_errs, exp_perr);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
